// File: rtl/morse_ctrl_pkg.sv
// ============================================================================
// Module   : morse_ctrl_pkg
// Brief    : Shared state encoding and counter widths for the Morse round
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_ctrl_pkg;

    localparam int ROUND_W = 4;
    localparam int MISS_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_RUN  = 3'd2,
        S_HIT  = 3'd3,
        S_MISS = 3'd4,
        S_OVER = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/morse_round_ctrl_tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Brief    : Free-running divider producing a registered one-cycle tick every
//            TICK_DIV enabled cycles; holds its count while disabled.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST_CNT) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

`default_nettype wire

// File: rtl/morse_round_ctrl.sv
// ============================================================================
// Module   : morse_round_ctrl
// Brief    : Round sequencer for the Morse game: arms the countdown, issues
//            per-second ticks, and tracks rounds and misses to win/game-over.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_round_ctrl #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MAX_ROUNDS = 9,
    parameter int MAX_MISSES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       answer_valid,
    input  logic       answer_correct,
    input  logic       timeout,
    output logic       reconfig,
    output logic       tick,
    output logic [3:0] round,
    output logic [1:0] misses,
    output logic       busy,
    output logic       game_over,
    output logic       win
);

    import morse_ctrl_pkg::*;

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS - 1);
    localparam logic [MISS_W-1:0]  LAST_MISS  = MISS_W'(MAX_MISSES - 1);

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic [MISS_W-1:0]  misses_q, misses_d;
    logic               win_q, win_d;
    logic               reconfig_q, reconfig_d;
    logic               busy_q, busy_d;
    logic               game_over_q, game_over_d;

    always_comb begin
        state_d  = state_q;
        round_d  = round_q;
        misses_d = misses_q;
        win_d    = win_q;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    round_d  = '0;
                    misses_d = '0;
                    win_d    = 1'b0;
                    state_d  = S_ARM;
                end
            end
            S_ARM: state_d = S_RUN;
            S_RUN: begin
                // A timeout in the same cycle as an answer still costs the round.
                if (timeout) begin
                    state_d = S_MISS;
                end else if (answer_valid) begin
                    state_d = answer_correct ? S_HIT : S_MISS;
                end
            end
            S_HIT: begin
                if (round_q == LAST_ROUND) begin
                    win_d   = 1'b1;
                    state_d = S_OVER;
                end else begin
                    round_d = round_q + 1'b1;
                    state_d = S_ARM;
                end
            end
            S_MISS: begin
                misses_d = misses_q + 1'b1;
                if (misses_q == LAST_MISS) begin
                    win_d   = 1'b0;
                    state_d = S_OVER;
                end else begin
                    state_d = S_ARM;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they line up with it.
        reconfig_d  = (state_d == S_ARM);
        busy_d      = (state_d == S_ARM) || (state_d == S_RUN) ||
                      (state_d == S_HIT) || (state_d == S_MISS);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            round_q     <= '0;
            misses_q    <= '0;
            win_q       <= 1'b0;
            reconfig_q  <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            misses_q    <= misses_d;
            win_q       <= win_d;
            reconfig_q  <= reconfig_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == S_ARM),
        .en   ((state_q == S_RUN) && !pause),
        .tick (tick)
    );

    assign reconfig  = reconfig_q;
    assign round     = round_q;
    assign misses    = misses_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;
    assign win       = win_q;

endmodule

`default_nettype wire
